text_writer: RTL

Character-buffer writer for the text-mode video path. It accepts a stream of glyph codes and console commands over a valid/ready handshake. It maintains a cursor and writes glyphs into the dual-port character RAM that the text-mode renderer scans out. It also handles line wrap, newline, home, clear-screen and one-line scroll-up, using the RAM's second read port.

---
 rtl/text_writer_pkg.sv | 11 +
 rtl/text_writer_cursor.sv | 58 +++++
 rtl/text_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/text_writer_pkg.sv
// text_writer_pkg: shared text-mode constants, console opcodes and writer FSM states
package text_writer_pkg;
    localparam int TEXT_CHARS_H   = 80;
    localparam int TEXT_CHARS_V   = 30;
    localparam int TEXT_BITS_CHAR = 7;
    localparam int TEXT_BITS_ADDR = $clog2(TEXT_CHARS_H * TEXT_CHARS_V);
    localparam logic [TEXT_BITS_CHAR-1:0] GLYPH_BLANK = 7'd2;
    localparam logic [TEXT_BITS_CHAR-1:0] GLYPH_ZERO  = 7'd3;
    typedef enum logic [1:0] {OP_PUT, OP_NEWLINE, OP_HOME, OP_CLEAR} text_op_e;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COPY, S_BLANK} text_state_e;
endpackage

// File: rtl/text_writer_cursor.sv
// text_cursor: cursor x/y counters plus incrementally kept linear address
// Ports: clk, rst_n (sync, active-low); adv/nl/home commands; x, y, addr, wrap (last column), last_row.
module text_cursor #(
    parameter int CHARS_H   = 80,
    parameter int CHARS_V   = 30,
    parameter int ADDR_BITS = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adv,
    input  logic                         nl,
    input  logic                         home,
    output logic [$clog2(CHARS_H)-1:0]   x,
    output logic [$clog2(CHARS_V)-1:0]   y,
    output logic [ADDR_BITS-1:0]         addr,
    output logic                         wrap,
    output logic                         last_row
);
    localparam int XW = $clog2(CHARS_H);
    localparam int YW = $clog2(CHARS_V);
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    assign wrap     = x_q == XW'(CHARS_H - 1);
    assign last_row = y_q == YW'(CHARS_V - 1);
    assign x        = x_q;
    assign y        = y_q;
    assign addr     = addr_q;
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (home) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (nl || (adv && wrap)) begin
            // back to column 0 of this row, then down one row unless at the bottom (scroll keeps the row)
            x_d    = '0;
            y_d    = last_row ? y_q : y_q + 1'b1;
            addr_d = addr_q - ADDR_BITS'(x_q) + (last_row ? '0 : ADDR_BITS'(CHARS_H));
        end else if (adv) begin
            x_d    = x_q + 1'b1;
            addr_d = addr_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/text_writer.sv
// text_writer: glyph/command stream to character RAM writer with wrap, clear and scroll-up
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_op/in_char command stream;
// wr_en/wr_addr/wr_data RAM write port; rd_addr/rd_data RAM read port (1-cycle latency);
// cursor_x/cursor_y current cursor; busy while clearing or scrolling.
module text_writer import text_writer_pkg::*; #(
    parameter int                   CHARS_H   = TEXT_CHARS_H,
    parameter int                   CHARS_V   = TEXT_CHARS_V,
    parameter int                   CHAR_BITS = TEXT_BITS_CHAR,
    parameter int                   ADDR_BITS = TEXT_BITS_ADDR,
    parameter logic [CHAR_BITS-1:0] BLANK     = GLYPH_BLANK
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [CHAR_BITS-1:0]         in_char,
    output logic                         wr_en,
    output logic [ADDR_BITS-1:0]         wr_addr,
    output logic [CHAR_BITS-1:0]         wr_data,
    output logic [ADDR_BITS-1:0]         rd_addr,
    input  logic [CHAR_BITS-1:0]         rd_data,
    output logic [$clog2(CHARS_H)-1:0]   cursor_x,
    output logic [$clog2(CHARS_V)-1:0]   cursor_y,
    output logic                         busy
);
    localparam logic [ADDR_BITS-1:0] LAST      = ADDR_BITS'(CHARS_H * CHARS_V - 1);
    localparam logic [ADDR_BITS-1:0] COPY_LAST = ADDR_BITS'((CHARS_V - 1) * CHARS_H - 1);
    localparam logic [ADDR_BITS-1:0] ROW       = ADDR_BITS'(CHARS_H);
    text_state_e          state_q, state_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [CHAR_BITS-1:0] wr_data_q, wr_data_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 copy_q, copy_d;
    logic                 busy_q, busy_d;
    logic                 adv, nl, home, wrap, last_row;
    logic [ADDR_BITS-1:0] cur_addr;
    text_cursor #(.CHARS_H(CHARS_H), .CHARS_V(CHARS_V), .ADDR_BITS(ADDR_BITS)) u_cursor (
        .clk(clk), .rst_n(rst_n), .adv(adv), .nl(nl), .home(home),
        .x(cursor_x), .y(cursor_y), .addr(cur_addr), .wrap(wrap), .last_row(last_row)
    );
    assign in_ready = state_q == S_IDLE;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    // a copy write forwards the RAM read data of the previous cycle's rd_addr
    assign wr_data  = copy_q ? rd_data : wr_data_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        copy_d    = 1'b0;
        busy_d    = busy_q;
        adv       = 1'b0;
        nl        = 1'b0;
        home      = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid) begin
                adv  = in_op == OP_PUT;
                nl   = in_op == OP_NEWLINE;
                home = in_op == OP_HOME;
                if (adv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr;
                    wr_data_d = in_char;
                end
                if (in_op == OP_CLEAR) begin
                    state_d   = S_CLEAR;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = BLANK;
                end
                if (((adv && wrap) || nl) && last_row) begin
                    state_d   = S_COPY;
                    busy_d    = 1'b1;
                    rd_addr_d = ROW;
                end
            end
            S_COPY: begin
                wr_en_d   = 1'b1;
                copy_d    = 1'b1;
                rd_addr_d = rd_addr_q == LAST ? rd_addr_q : rd_addr_q + 1'b1;
                if (!copy_q) begin
                    wr_addr_d = '0;
                end else if (wr_addr_q == COPY_LAST) begin
                    copy_d    = 1'b0;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = BLANK;
                    state_d   = S_BLANK;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            default: begin
                wr_en_d   = wr_addr_q != LAST;
                wr_addr_d = wr_addr_q == LAST ? wr_addr_q : wr_addr_q + 1'b1;
                if (wr_addr_q == LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    home    = state_q == S_CLEAR;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            copy_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            copy_q    <= copy_d;
            busy_q    <= busy_d;
        end
    end
endmodule
